fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the static frontend predictor.
- Owns the fetch PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Presents each returned {pc, instr} to the predictor combinationally and takes the predicted target as the next fetch PC.
- Buffers fetched entries {pc, instr, pred} in a small queue towards decode; backend redirects flush the queue and restart fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address issued first after reset.
- FQ_DEPTH, 4, fetch-queue entries (power of two, >=2).

Ports:
- clk, input, 1, clock, rising edge.
- resetn, input, 1, synchronous active-low reset.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_ready, input, 1, memory accepts request.
- imem_req_addr, output, 32, word address; bits[1:0] always 00.
- imem_resp_valid, input, 1, response valid; at least 1 cycle after acceptance, in order.
- imem_resp_data, input, 32, fetched instruction.
- pred_pc, output, 32, PC of instruction currently returning, to predictor.
- pred_instr, output, 32, instruction currently returning, to predictor.
- pred_target, input, 32, predictor's next-PC for pred_pc/pred_instr (combinational).
- redirect_valid, input, 1, backend mispredict or exception redirect.
- redirect_pc, input, 32, restart address; bits[1:0] ignored.
- out_valid, output, 1, queue head valid to decode.
- out_ready, input, 1, decode accepts head.
- out_pc, output, 32, head PC.
- out_instr, output, 32, head instruction.
- out_pred, output, 32, head predicted next PC, carried for backend compare.

Behaviour:
- One clock. Reset is synchronous and active-low.
- Reset (resetn=0 at a clk edge):
  - fetch_pc=RESET_PC, state=IDLE, queue empty, outstanding-request bookkeeping cleared.
  - While resetn=0: imem_req_valid=0, out_valid=0.
  - Reset mid-request: any later response to that request is ignored; bench must not send one.
- At most one outstanding request. States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DROP: request outstanding, response stale.
- Space rule: a request may be issued only if occupancy after this cycle's push/pop is < FQ_DEPTH. This reserves a slot, so a non-stale response is never lost.
- IDLE:
  - imem_req_valid = space, addr = fetch_pc.
  - On handshake -> WAIT.
- WAIT without response:
  - imem_req_valid=0.
- WAIT with imem_resp_valid:
  - pred_pc = pc of the outstanding request; pred_instr = imem_resp_data.
  - Push {pred_pc, imem_resp_data, pred_target}.
  - Back-to-back: same cycle, imem_req_valid = space, addr = pred_target. Handshake -> stay WAIT; otherwise fetch_pc=pred_target -> IDLE.
- DROP:
  - imem_req_valid=0.
  - On response: discard it, no push -> IDLE, using the fetch_pc already set by the redirect.
- Redirect has priority over every other event in its cycle:
  - Queue flushed (pop and push suppressed); fetch_pc = {redirect_pc[31:2], 2'b00}.
  - From IDLE: no request issued in the redirect cycle; stay IDLE.
  - From WAIT: -> DROP, or -> IDLE if the response arrives in the same cycle (it is discarded).
  - From DROP: stay DROP, update fetch_pc.
  - Any request handshaken in the redirect cycle is suppressed: imem_req_valid forced 0.
- Queue:
  - FIFO with circular pointers, wrap at FQ_DEPTH.
  - out_* driven from head register; out_valid = occupancy != 0.
  - Pop on out_valid && out_ready; simultaneous push and pop allowed at any occupancy including full (space rule guarantees no overflow).
  - Empty queue: out_valid=0, no pass-through of an arriving response (min 1-cycle latency response->out_valid).
- pred_pc/pred_instr are defined only when state=WAIT and imem_resp_valid; otherwise they hold pc-register/resp_data values and are don't-care.
- PC arithmetic is 32-bit, wraps modulo 2^32.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {pc, instr, pred} (96 bits).
  - fetch_state_t enum {IDLE, WAIT, DROP}.
  - Default RESET_PC constant.
- Sub-module fetch_queue (parameter FQ_DEPTH; push/pop, fetch_entry_t data, count output for the space rule). fetch_stage holds FSM, fetch_pc, outstanding-PC register.

Test Plan:
- Reset, 1-cycle memory, out_ready=1, straight-line code -> req addrs 0x0,0x4,0x8 on consecutive cycles; out_pc 0x0,0x4,0x8 with out_pred=out_pc+4.
- Response at pc 0x10 is j 0x100 (pred_target=0x100) -> next imem_req_addr=0x100 in the response cycle; out_pred of entry 0x10 = 0x100.
- out_ready=0 for 10 cycles, FQ_DEPTH=4 -> exactly 4 entries buffered, imem_req_valid low once count+outstanding=4; releasing out_ready resumes fetch with no lost or duplicated PC.
- Redirect to 0x200 while request to 0x20 outstanding (3-cycle memory) -> queue emptied, response for 0x20 dropped, next request addr 0x200, first out_pc=0x200.
- Redirect in the same cycle as the response and an out_ready pop -> no push, no pop effect, queue empty next cycle, next request addr=redirect_pc; redirect_pc=0x203 -> request addr 0x200.
- resetn low for one cycle mid-stream with a full queue -> next cycle out_valid=0, first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched entries towards decode; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output logic                       out_valid,
    output fetch_entry_t               out_data,
    output logic [$clog2(FQ_DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t      mem [FQ_DEPTH];
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Push into a full queue with a pop writes the slot the head is vacating.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight and
// queues {pc, instr, pred} towards decode. Redirects flush the queue and restart fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pred_pc,
    output logic [31:0] pred_instr,
    input  logic [31:0] pred_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pred
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;

    logic          resp_fire;
    logic          push, pop, req_fire, space;
    logic          q_valid;
    logic [CW-1:0] q_count;
    logic [OW-1:0] occ_next;
    logic [31:0]   target_aligned;
    fetch_entry_t  push_data, q_data;

    assign resp_fire      = (state_q == StWait) && imem_resp_valid;
    assign target_aligned = pred_target & ALIGN_MASK;

    assign push = resetn && resp_fire && !redirect_valid;
    assign pop  = resetn && q_valid && out_ready && !redirect_valid;

    // A request reserves a queue slot, so its response can always be pushed.
    assign occ_next = OW'(q_count) + OW'(push) - OW'(pop);
    assign space    = occ_next < OW'(FQ_DEPTH);

    assign imem_req_valid = resetn && !redirect_valid && space
                            && ((state_q == StIdle) || resp_fire);
    assign imem_req_addr  = resp_fire ? target_aligned : fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign pred_pc    = req_pc_q;
    assign pred_instr = imem_resp_data;

    assign push_data = '{pc: req_pc_q, instr: imem_resp_data, pred: pred_target};

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .out_valid (q_valid),
        .out_data  (q_data),
        .count     (q_count)
    );

    assign out_valid = resetn && q_valid;
    assign out_pc    = q_data.pc;
    assign out_instr = q_data.instr;
    assign out_pred  = q_data.pred;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            // A response arriving alongside the redirect retires the stale request.
            if (state_q != StIdle) state_d = imem_resp_valid ? StIdle : StDrop;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        state_d  = StWait;
                        req_pc_d = fetch_pc_q;
                    end
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        if (req_fire) begin
                            req_pc_d = target_aligned;
                        end else begin
                            fetch_pc_d = target_aligned;
                            state_d    = StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (imem_resp_valid) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            req_pc_q   <= RESET_PC & ALIGN_MASK;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a program-order model of the fetch stream.
module tb_fetch_stage;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic [31:0] pred_pc, pred_instr, pred_target;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_pc, out_instr, out_pred;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .pred_pc         (pred_pc),
        .pred_instr      (pred_instr),
        .pred_target     (pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_pred        (out_pred)
    );

    // Program image: word at [7:2]==4 is "j addr+0xF0", everything else an addi.
    function automatic logic [31:0] imem(input logic [31:0] a);
        logic [31:0] t;
        if (a[7:2] == 6'd4) begin
            t = (a + 32'h0000_00F0) >> 2;
            return {6'h02, t[25:0]};
        end
        return {6'h08, 10'h001, a[15:0]};
    endfunction

    function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] ins);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        if (ins[31:26] == 6'h02) return {pc4[31:28], ins[25:0], 2'b00};
        return pc4;
    endfunction

    function automatic logic [31:0] pfn(input logic [31:0] a);
        return predict(a, imem(a));
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb pred_target = predict(pred_pc, pred_instr);

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Model and memory-responder state.
    int          occ = 0;
    logic [31:0] exp_out = RST_PC, exp_req = RST_PC, mem_addr = '0;
    bit          mem_busy = 0, stale = 0, rnd = 0;
    int          mem_lat = 0, lat_min = 0, lat_max = 0;
    logic [31:0] req_log[$], out_pc_log[$], out_pred_log[$];
    int          req_cyc[$];

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        out_pc_log.delete();
        out_pred_log.delete();
    endtask

    always @(negedge clk) begin : cmp
        logic real_resp, do_pop, exp_v, hs;
        int   occ_next;
        if (!resetn) begin
            chk("rst_req_valid", imem_req_valid, 32'd0);
            chk("rst_out_valid", out_valid, 32'd0);
            occ = 0; exp_out = RST_PC; exp_req = RST_PC; mem_busy = 0; stale = 0;
        end else begin
            real_resp = imem_resp_valid && !stale;
            chk("out_valid", out_valid, occ != 0);
            do_pop = (occ != 0) && out_ready && !redirect_valid;
            if (do_pop) begin
                chk("out_pc", out_pc, exp_out);
                chk("out_instr", out_instr, imem(exp_out));
                chk("out_pred", out_pred, pfn(exp_out));
                out_pc_log.push_back(out_pc);
                out_pred_log.push_back(out_pred);
                exp_out = pfn(exp_out);
            end
            if (real_resp) begin
                chk("pred_pc", pred_pc, mem_addr);
                chk("pred_instr", pred_instr, imem(mem_addr));
            end
            occ_next = redirect_valid ? 0 : occ + int'(real_resp) - int'(do_pop);
            if (occ_next > int'(DEPTH)) chk("fq_overflow", occ_next, DEPTH);
            exp_v = !redirect_valid && (!mem_busy || real_resp) && (occ_next < int'(DEPTH));
            chk("req_valid", imem_req_valid, exp_v);
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
            hs = imem_req_valid && imem_req_ready;
            if (imem_resp_valid) begin
                mem_busy = 0; stale = 0;
            end else if (mem_busy) begin
                if (redirect_valid) stale = 1;
                if (mem_lat > 0) mem_lat--;
            end
            if (hs) begin
                mem_busy = 1;
                mem_addr = imem_req_addr;
                mem_lat  = $urandom_range(lat_max, lat_min);
                req_log.push_back(imem_req_addr);
                req_cyc.push_back(cyc);
            end
            if (redirect_valid) begin
                exp_out = redirect_pc & 32'hFFFF_FFFC;
                exp_req = redirect_pc & 32'hFFFF_FFFC;
            end else if (hs) begin
                exp_req = pfn(exp_req);
            end
            occ = occ_next;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_busy && mem_lat == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = imem(mem_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        if (rnd) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | $urandom_range(0, 31))
                                                         : ($urandom & 32'h0000_03FF);
            resetn         = ($urandom_range(0, 299) != 0);
        end
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        clear_logs();
    endtask

    initial begin
        bit found;

        // Straight-line fetch with a 1-cycle memory, then the jump at 0x10.
        lat_min = 0; lat_max = 0;
        do_reset();
        repeat (12) tick();
        chk("t1_req0", qget(req_log, 0), 32'h0);
        chk("t1_req1", qget(req_log, 1), 32'h4);
        chk("t1_req2", qget(req_log, 2), 32'h8);
        chk("t1_consecutive", req_cyc[2] - req_cyc[0], 32'd2);
        chk("t1_out0", qget(out_pc_log, 0), 32'h0);
        chk("t1_out1", qget(out_pc_log, 1), 32'h4);
        chk("t1_out2", qget(out_pc_log, 2), 32'h8);
        chk("t1_pred0", qget(out_pred_log, 0), 32'h4);
        chk("t1_pred2", qget(out_pred_log, 2), 32'hC);
        chk("t1_jump_req", qget(req_log, 5), 32'h100);
        chk("t1_jump_b2b", req_cyc[5] - req_cyc[4], 32'd1);
        chk("t1_jump_pred", qget(out_pred_log, 4), 32'h100);

        // Decode stall fills the queue; no request beyond the reserved slots.
        do_reset();
        out_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("t2_req_count", req_log.size(), 32'd4);
        chk("t2_req_blocked", imem_req_valid, 32'd0);
        chk("t2_out_valid", out_valid, 32'd1);
        tick();
        out_ready = 1'b1;
        repeat (20) tick();
        chk("t2_resume4", qget(out_pc_log, 4), 32'h10);
        chk("t2_resume5", qget(out_pc_log, 5), 32'h100);

        // Reset with a full queue.
        out_ready = 1'b0;
        repeat (10) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        clear_logs();
        @(negedge clk);
        chk("t6_out_valid", out_valid, 32'd0);
        repeat (3) tick();
        chk("t6_first_req", qget(req_log, 0), RST_PC);
        out_ready = 1'b1;

        // Redirect while the 0x20 request is outstanding on a 3-cycle memory.
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        lat_min = 2; lat_max = 2;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            foreach (req_log[k]) if (req_log[k] == 32'h20) found = 1;
        end
        chk("t4_req20_seen", found, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        clear_logs();
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        chk("t4_req_first", qget(req_log, 0), 32'h200);
        chk("t4_out_first", qget(out_pc_log, 0), 32'h200);
        chk("t4_out_second", qget(out_pc_log, 1), 32'h204);

        // Redirect coinciding with a response and a pop; unaligned restart address.
        lat_min = 0; lat_max = 0;
        do_reset();
        repeat (4) tick();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_resp_valid && out_valid) found = 1;
        end
        chk("t5_window", found, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        clear_logs();
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_empty", out_valid, 32'd0);
        repeat (10) tick();
        chk("t5_req_first", qget(req_log, 0), 32'h200);
        chk("t5_out_first", qget(out_pc_log, 0), 32'h200);

        // Randomized traffic, including wrap past 0xFFFF_FFFC.
        lat_min = 0; lat_max = 3;
        rnd = 1;
        repeat (4000) tick();
        rnd = 0;
        resetn = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
